// File: rtl/p2s_rr_scheduler.sv
// -----------------------------------------------------------------------------
// p2s_rr_scheduler
// Round-robin scheduler that picks one word at a time from NREQ requester
// channels and offers it to a downstream parallel-to-serial converter.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous, active-high reset
//   en         - scheduler enable; gates new grants only
//   req_mask   - per-channel enable (0 = channel ineligible)
//   req_valid  - per-channel word available
//   req_data   - channel i word at [i*N +: N]
//   req_ready  - per-channel accept, one-hot or zero
//   par_data   - word offered to the serializer
//   par_valid  - par_data valid
//   par_ready  - serializer accepts the word
//   grant_id   - index of the channel whose word is held
//   busy       - high while a word is held (OFFER state)
//   word_cnt   - count of words handed to the serializer, wraps to 0
// -----------------------------------------------------------------------------
module p2s_rr_scheduler #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_mask,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      par_data,
  output logic              par_valid,
  input  logic              par_ready,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic [15:0]       word_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [0:0]    r_state;
  logic [GW-1:0] r_rr_ptr;
  logic [GW-1:0] r_grant;
  logic [N-1:0]  r_hold;
  logic [15:0]   r_word_cnt;

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [GW-1:0]   w_sel_idx;
  logic            w_take;
  logic [GW-1:0]   w_ptr_next;
  logic [N-1:0]    w_words [NREQ];

  assign w_elig = req_valid & req_mask;

  // Split the flat request bus into one word per channel.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_words[i] = req_data[i*N +: N];
    end
  end

  // Find the first eligible channel at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin : p_search
    logic [GW:0] v_cand;
    w_found   = 1'b0;
    w_sel_idx = '0;
    v_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit keeps ptr+k from overflowing before the modulo fold.
      v_cand = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (v_cand >= (GW+1)'(NREQ)) begin
        v_cand = v_cand - (GW+1)'(NREQ);
      end else begin
        v_cand = v_cand;
      end
      if (!w_found && w_elig[v_cand[GW-1:0]]) begin
        w_found   = 1'b1;
        w_sel_idx = v_cand[GW-1:0];
      end else begin
        w_found   = w_found;
        w_sel_idx = w_sel_idx;
      end
    end
  end

  // A selection only happens from IDLE with the scheduler enabled; reset wins.
  assign w_take = (r_state == ST_IDLE) && en && w_found && !rst;

  // Next round-robin pointer: one past the winner, NREQ-1 folds back to 0.
  always_comb begin
    if (w_sel_idx == GW'(NREQ-1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_sel_idx + GW'(1);
    end
  end

  // Combinational one-hot accept toward the selected requester.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_take && (w_sel_idx == GW'(i));
    end
  end

  // State, hold register, grant, pointer and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_hold     <= '0;
      r_word_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_hold   <= w_words[w_sel_idx];
            r_grant  <= w_sel_idx;
            r_rr_ptr <= w_ptr_next;
            r_state  <= ST_OFFER;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_OFFER: begin
          // Held word, grant and pointer are frozen until the serializer takes it.
          if (par_ready) begin
            r_word_cnt <= r_word_cnt + 16'd1;
            r_state    <= ST_IDLE;
          end else begin
            r_state    <= ST_OFFER;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // par_valid is masked by rst so a word being discarded is never handed off.
  assign par_valid = (r_state == ST_OFFER) && !rst;
  assign par_data  = r_hold;
  assign grant_id  = r_grant;
  assign busy      = (r_state == ST_OFFER);
  assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_p2s_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_p2s_rr_scheduler
// Directed, self-checking bench for p2s_rr_scheduler (N=4, NREQ=4). Expected
// grants are queued when a request is set up and popped when the word is
// offered to the serializer.
// -----------------------------------------------------------------------------
module tb_p2s_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req_mask;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  par_data;
  logic        par_valid;
  logic        par_ready;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] word_cnt;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
  } exp_t;

  exp_t       sb[$];
  int         order_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         exp_cnt = 0;
  logic [3:0] tbl [4];

  p2s_rr_scheduler #(.N(4), .NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_mask  (req_mask),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .par_data  (par_data),
    .par_valid (par_valid),
    .par_ready (par_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic look();
    #1;
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id   = 2'(id);
    e.data = tbl[id];
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_grant"}, 32'(grant_id), 32'(e.id));
      chk({tag, "_data"},  32'(par_data), 32'(e.data));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    look();
    step();
    rst = 1'b0;
    exp_cnt = 0;
    sb.delete();
  endtask

  // Expect the grant order in order_q; one word per 2 cycles with par_ready=1.
  task automatic run_seq(input string tag);
    int n;
    n = order_q.size();
    foreach (order_q[j]) push(order_q[j]);
    for (int c = 0; c < 2 * n; c++) begin
      look();
      chk({tag, "_par_valid"}, 32'(par_valid), 32'(c % 2));
      if (c % 2 == 0) begin
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1 << order_q[c / 2]);
      end else begin
        chk({tag, "_req_ready_off"}, 32'(req_ready), 32'd0);
        pop_check(tag);
        exp_cnt++;
      end
      step();
    end
  endtask

  initial begin
    tbl[0] = 4'b0011;
    tbl[1] = 4'b1101;
    tbl[2] = 4'b1011;
    tbl[3] = 4'b0110;
    req_data  = {tbl[3], tbl[2], tbl[1], tbl[0]};
    rst       = 1'b1;
    en        = 1'b1;
    req_mask  = 4'hF;
    req_valid = 4'hF;
    par_ready = 1'b1;

    // Reset: outputs held quiet while rst is high, registers cleared after edge.
    look();
    chk("rst_req_ready_pre", 32'(req_ready), 32'd0);
    chk("rst_par_valid_pre", 32'(par_valid), 32'd0);
    step();
    look();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_grant",     32'(grant_id),  32'd0);
    chk("rst_word_cnt",  32'(word_cnt),  32'd0);
    chk("rst_par_data",  32'(par_data),  32'd0);
    rst = 1'b0;
    req_valid = 4'h0;

    // Single request on ch2.
    req_valid = 4'b0100;
    look();
    chk("single_req_ready", 32'(req_ready), 32'b0100);
    chk("single_idle_pv",   32'(par_valid), 32'd0);
    push(2);
    step();
    req_valid = 4'b0000;
    look();
    chk("single_ready_off", 32'(req_ready), 32'd0);
    chk("single_par_valid", 32'(par_valid), 32'd1);
    chk("single_busy",      32'(busy),      32'd1);
    pop_check("single");
    exp_cnt++;
    step();
    look();
    chk("single_word_cnt",  32'(word_cnt),  32'(exp_cnt));
    chk("single_pv_low",    32'(par_valid), 32'd0);
    chk("single_busy_low",  32'(busy),      32'd0);
    chk("single_data_hold", 32'(par_data),  32'b1011);

    // Full contention from reset.
    do_reset();
    req_valid = 4'hF;
    order_q = {0, 1, 2, 3, 0};
    run_seq("contend");
    req_valid = 4'h0;
    look();
    chk("contend_word_cnt", 32'(word_cnt), 32'(exp_cnt));

    // Backpressure on ch1 (rr_ptr now 1); input changes during OFFER ignored.
    req_valid = 4'b0010;
    par_ready = 1'b0;
    look();
    chk("bp_req_ready", 32'(req_ready), 32'b0010);
    push(1);
    step();
    req_valid = 4'hF;
    req_mask  = 4'h0;
    for (int c = 0; c < 5; c++) begin
      look();
      chk("bp_par_valid", 32'(par_valid), 32'd1);
      chk("bp_par_data",  32'(par_data),  32'b1101);
      chk("bp_grant",     32'(grant_id),  32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_word_cnt",  32'(word_cnt),  32'(exp_cnt));
      step();
    end
    par_ready = 1'b1;
    look();
    pop_check("bp");
    exp_cnt++;
    step();
    req_mask  = 4'hF;
    req_valid = 4'h0;
    look();
    chk("bp_word_cnt_after", 32'(word_cnt),  32'(exp_cnt));
    chk("bp_pv_after",       32'(par_valid), 32'd0);

    // Mask out ch2.
    do_reset();
    req_mask  = 4'b1011;
    req_valid = 4'hF;
    order_q = {0, 1, 3, 0};
    run_seq("mask");
    req_valid = 4'h0;
    req_mask  = 4'hF;
    look();
    chk("mask_word_cnt", 32'(word_cnt), 32'(exp_cnt));

    // Reset while ch3 is held (rr_ptr now 1).
    req_mask  = 4'b1000;
    req_valid = 4'hF;
    look();
    chk("rmid_req_ready", 32'(req_ready), 32'b1000);
    step();
    look();
    chk("rmid_par_valid", 32'(par_valid), 32'd1);
    chk("rmid_grant",     32'(grant_id),  32'd3);
    chk("rmid_data",      32'(par_data),  32'b0110);
    rst = 1'b1;
    look();
    chk("rmid_pv_in_rst", 32'(par_valid), 32'd0);
    chk("rmid_rr_in_rst", 32'(req_ready), 32'd0);
    step();
    exp_cnt = 0;
    sb.delete();
    rst = 1'b0;
    req_mask = 4'hF;
    look();
    chk("rmid_busy",      32'(busy),      32'd0);
    chk("rmid_pv_after",  32'(par_valid), 32'd0);
    chk("rmid_grant0",    32'(grant_id),  32'd0);
    chk("rmid_word_cnt",  32'(word_cnt),  32'd0);
    chk("rmid_data0",     32'(par_data),  32'd0);
    chk("rmid_first_rr",  32'(req_ready), 32'b0001);
    push(0);
    step();
    look();
    pop_check("rmid");
    exp_cnt++;
    step();
    req_valid = 4'h0;
    look();
    chk("rmid_word_cnt1", 32'(word_cnt), 32'(exp_cnt));

    // Enable gating; an offer already in flight completes with en=0.
    do_reset();
    en = 1'b0;
    req_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin
      look();
      chk("en_req_ready", 32'(req_ready), 32'd0);
      chk("en_par_valid", 32'(par_valid), 32'd0);
      step();
    end
    en = 1'b1;
    look();
    chk("en_first_rr", 32'(req_ready), 32'b0001);
    push(0);
    step();
    en = 1'b0;
    look();
    chk("en_off_pv", 32'(par_valid), 32'd1);
    pop_check("en_off");
    exp_cnt++;
    step();
    look();
    chk("en_word_cnt", 32'(word_cnt),  32'(exp_cnt));
    chk("en_rr_low",   32'(req_ready), 32'd0);
    chk("en_pv_low",   32'(par_valid), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/p2s_rr_scheduler.md
P2S_RR_SCHEDULER -- requirements
Module: p2s_rr_scheduler

Interface
REQ-001 SHALL have parameter N, default 4: parallel word width, equal to the downstream serializer width.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters, at least 2.
REQ-003 SHALL have parameter GW, default $clog2(NREQ): width of the grant index.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: scheduler enable; gates new grants only.
REQ-007 SHALL have port req_mask, input, NREQ bits: per-channel enable; bit i = 0 makes channel i ineligible.
REQ-008 SHALL have port req_valid, input, NREQ bits: per-channel word available.
REQ-009 SHALL have port req_data, input, NREQ*N bits: channel i word at [i*N +: N].
REQ-010 SHALL have port req_ready, output, NREQ bits: per-channel accept, one-hot or zero.
REQ-011 SHALL have port par_data, output, N bits: word offered to the serializer.
REQ-012 SHALL have port par_valid, output, 1 bit: par_data valid.
REQ-013 SHALL have port par_ready, input, 1 bit: serializer accepts the word.
REQ-014 SHALL have port grant_id, output, GW bits: index of the channel whose word is held.
REQ-015 SHALL have port busy, output, 1 bit: high while a word is held.
REQ-016 SHALL have port word_cnt, output, 16 bits: count of words handed to the serializer; wraps at 16'hFFFF to 0.

Function
REQ-017 SHALL implement a two-state FSM with states IDLE and OFFER.
REQ-018 Eligibility: channel i SHALL be eligible when req_valid[i] & req_mask[i].
REQ-019 IDLE: when en=1 and any channel is eligible, the block SHALL select the first eligible channel searching upward from rr_ptr, modulo NREQ.
REQ-020 IDLE: the block SHALL assert req_ready for the selected channel only, combinationally in the same cycle; req_ready SHALL be 0 when there is no selection.
REQ-021 On the edge of an IDLE selection, the block SHALL:
- capture the winner's data into the hold register;
- set grant_id to the winner;
- set rr_ptr to (winner+1) mod NREQ, so NREQ-1 wraps to 0;
- enter OFFER.
REQ-022 OFFER: par_valid SHALL be 1, par_data SHALL equal the hold register, and req_ready SHALL be all 0.
REQ-023 OFFER: par_data and grant_id SHALL stay stable until par_ready=1.
REQ-024 OFFER with par_ready=1: on that edge the block SHALL increment word_cnt by 1 and return to IDLE.
REQ-025 Latency: par_valid SHALL rise in the cycle after the requester handshake.
REQ-026 Throughput: the block SHALL deliver at most one word per 2 cycles.
REQ-027 In IDLE, par_valid SHALL be 0 and par_data SHALL hold its last value.
REQ-028 busy SHALL be 1 exactly when the state is OFFER.
REQ-029 en=0 SHALL block new selections only; a word already in OFFER SHALL complete normally.
REQ-030 Changes to req_mask or req_valid during OFFER SHALL NOT affect the held word; eligibility is re-evaluated in IDLE.
REQ-031 A channel deasserting req_valid before it is selected SHALL lose no data and SHALL not change rr_ptr.
REQ-032 When a single channel is the only eligible one, it SHALL win every IDLE cycle; there is no starvation penalty.

Reset
REQ-033 With rst=1 at an edge, the block SHALL set:
- state to IDLE and rr_ptr to 0;
- grant_id to 0 and word_cnt to 0;
- the hold register and par_data to 0.
REQ-034 While rst=1, req_ready SHALL be 0 and par_valid SHALL be 0.
REQ-035 rst=1 in OFFER SHALL discard the held word without a par_ready handshake; word_cnt SHALL not increment.
REQ-036 rst SHALL take priority over every other event in the same cycle.

Verification
REQ-037 Single request: ch2 req_data=4'b1011, req_valid=4'b0100, mask=4'hF, par_ready=1. Required: req_ready=4'b0100 for 1 cycle; next cycle par_valid=1, par_data=1011, grant_id=2; word_cnt becomes 1.
REQ-038 Full contention: all four channels valid continuously, par_ready=1, from reset. Required: grant order 0,1,2,3,0 with a new par_valid every 2 cycles.
REQ-039 Backpressure: par_ready=0 for 5 cycles while ch1 holds 4'b1101. Required: par_valid, par_data=1101 and grant_id=1 stable; req_ready=0; one transfer once par_ready=1.
REQ-040 Mask: mask=4'b1011, all channels valid. Required: grant order 0,1,3,0; ch2 never readied.
REQ-041 Reset mid-OFFER: rst=1 while ch3 holds 4'b0110. Required next cycle: par_valid=0, busy=0, grant_id=0, word_cnt unchanged by the drop; first post-reset grant goes to ch0 when all channels are valid.
REQ-042 Enable: en=0 with req_valid=4'hF for 4 cycles. Required: req_ready=0 and par_valid=0; the cycle en=1 yields req_ready=4'b0001.
